// File: rtl/cluster_seq_pkg.sv
// -----------------------------------------------------------------------------
// cluster_seq_pkg
// Shared types for the cluster power sequencer:
//   - state_e : sequencer states, with the 3-bit encodings driven on state_o
//   - cmd_t   : one SoC-side command (direction, fetch-enable request, boot address)
//   - seq_cnt_width() : sizes the single wait counter shared by every state
// -----------------------------------------------------------------------------
package cluster_seq_pkg;

    // Encodings visible to software through state_o.
    localparam logic [2:0] ST_OFF_ENC        = 3'd0;
    localparam logic [2:0] ST_PWR_ON_ENC     = 3'd1;
    localparam logic [2:0] ST_CLK_ON_ENC     = 3'd2;
    localparam logic [2:0] ST_RST_REL_ENC    = 3'd3;
    localparam logic [2:0] ST_RUN_ENC        = 3'd4;
    localparam logic [2:0] ST_DRAIN_ENC      = 3'd5;
    localparam logic [2:0] ST_RST_ASSERT_ENC = 3'd6;
    localparam logic [2:0] ST_PWR_OFF_ENC    = 3'd7;

    typedef enum logic [2:0] {
        OFF        = ST_OFF_ENC,
        PWR_ON     = ST_PWR_ON_ENC,
        CLK_ON     = ST_CLK_ON_ENC,
        RST_REL    = ST_RST_REL_ENC,
        RUN        = ST_RUN_ENC,
        DRAIN      = ST_DRAIN_ENC,
        RST_ASSERT = ST_RST_ASSERT_ENC,
        PWR_OFF    = ST_PWR_OFF_ENC
    } state_e;

    // Widest boot address a command can carry; narrower tops zero-extend into it.
    localparam int CMD_ADDR_W = 64;

    typedef struct packed {
        logic                  pwr_up;
        logic                  fetch_en;
        logic [CMD_ADDR_W-1:0] boot_addr;
    } cmd_t;

    // Counter must hold the largest reload value (max - 1) without wrapping.
    function automatic int seq_cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cluster_seq_timer.sv
// -----------------------------------------------------------------------------
// cluster_seq_timer
// Loadable down-counter shared by all sequencer waits. A load has priority;
// otherwise the count decrements and sticks at zero (never wraps).
// Ports:
//   clk_i       in   clock
//   rst_ni      in   asynchronous active-low reset (count -> 0)
//   load_i      in   load load_val_i this cycle
//   load_val_i  in   CNT_W reload value
//   zero_o      out  count is zero
// -----------------------------------------------------------------------------
module cluster_seq_timer
    import cluster_seq_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cluster_pwr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cluster_pwr_seq_ctrl
// Sequences cluster power-up/boot and drain/power-down from one SoC command
// port. Cluster-facing outputs are registered from the current state, so they
// follow a state change by one cycle; cmd_ready_o tracks the state directly.
//
// Optional build macro: CLUSTER_SEQ_TIMEOUT_EN
//   defined   : PWR_ON, DRAIN and PWR_OFF give up after TIMEOUT_CYC cycles and
//               set the sticky err_o (cleared by the next accepted command).
//   undefined : those states wait forever; err_o is tied low.
//
// Ports:
//   clk_i, rst_ni               SoC clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o   command handshake (ready only in OFF and RUN)
//   cmd_pwr_up_i                1 = power-up + boot, 0 = drain + power-down
//   cmd_fetch_en_i              raise fetch enable when RUN is reached
//   cmd_boot_addr_i             boot address, captured on an up accept
//   pwr_ack_i                   PMU power-switch ack (level)
//   cluster_busy_i              cluster activity
//   cluster_pow_o               power switch request
//   cluster_clk_en_o            cluster clock gate enable
//   cluster_rstn_o              cluster reset, active low
//   cluster_fetch_enable_o      core fetch enable
//   cluster_boot_addr_o         captured boot address
//   state_o                     current state encoding
//   done_o                      one-cycle pulse when a sequence completes
//   err_o                       sticky timeout flag
// -----------------------------------------------------------------------------
module cluster_pwr_seq_ctrl
    import cluster_seq_pkg::*;
#(
    parameter int BOOT_ADDR_W = 64,
    parameter int CLK_SETTLE  = 4,
    parameter int RST_CYCLES  = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_pwr_up_i,
    input  logic                   cmd_fetch_en_i,
    input  logic [BOOT_ADDR_W-1:0] cmd_boot_addr_i,
    input  logic                   pwr_ack_i,
    input  logic                   cluster_busy_i,
    output logic                   cluster_pow_o,
    output logic                   cluster_clk_en_o,
    output logic                   cluster_rstn_o,
    output logic                   cluster_fetch_enable_o,
    output logic [BOOT_ADDR_W-1:0] cluster_boot_addr_o,
    output logic [2:0]             state_o,
    output logic                   done_o,
    output logic                   err_o
);

    localparam int CNT_W = seq_cnt_width(CLK_SETTLE, RST_CYCLES, TIMEOUT_CYC);

    // Reload values are "cycles in state - 1": the exit fires on the cycle the
    // counter reads zero, so a state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(CLK_SETTLE - 1);
    localparam logic [CNT_W-1:0] LD_RST    = CNT_W'(RST_CYCLES - 1);
`ifdef CLUSTER_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] LD_TMO    = CNT_W'(TIMEOUT_CYC - 1);
`endif

    state_e state_q, state_d;

    logic                   cmd_ready_q, cmd_ready_d;
    logic                   pow_q, pow_d;
    logic                   clk_en_q, clk_en_d;
    logic                   rstn_q, rstn_d;
    logic                   fetch_q, fetch_d;
    logic                   done_q, done_d;
    logic                   idle_q, idle_d;
    logic                   fetch_flag_q, fetch_flag_d;
    logic [BOOT_ADDR_W-1:0] boot_addr_q, boot_addr_d;

    cmd_t             cmd_in;
    logic             accept;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_zero;

`ifdef CLUSTER_SEQ_TIMEOUT_EN
    logic err_q, err_d;
`endif

    always_comb begin
        cmd_in.pwr_up    = cmd_pwr_up_i;
        cmd_in.fetch_en  = cmd_fetch_en_i;
        cmd_in.boot_addr = CMD_ADDR_W'(cmd_boot_addr_i);
    end

    // cmd_ready_q mirrors state_q (it is registered from state_d), so a plain
    // valid&ready handshake only fires in OFF or RUN.
    assign accept = cmd_valid_i & cmd_ready_q;

    cluster_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .zero_o     (tmr_zero)
    );

    // ------------------------------------------------------------------
    // Next-state and registered-output decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every value driven here gets a default first, so no branch can
        // leave one unassigned and infer a latch.
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        done_d       = 1'b0;
        fetch_flag_d = fetch_flag_q;
        boot_addr_d  = boot_addr_q;
`ifdef CLUSTER_SEQ_TIMEOUT_EN
        err_d        = err_q;
`endif

        // Two consecutive idle samples are needed in DRAIN; idle_q holds the
        // first and is cleared whenever we are not draining.
        idle_d = (state_q == DRAIN) & ~cluster_busy_i;

        unique case (state_q)
            OFF: begin
                if (accept) begin
                    if (cmd_in.pwr_up) begin
                        state_d      = PWR_ON;
                        fetch_flag_d = cmd_in.fetch_en;
                        boot_addr_d  = cmd_in.boot_addr[BOOT_ADDR_W-1:0];
`ifdef CLUSTER_SEQ_TIMEOUT_EN
                        tmr_load     = 1'b1;
                        tmr_load_val = LD_TMO;
`endif
                    end else begin
                        done_d = 1'b1;  // already off: acknowledge only
                    end
                end
            end

            PWR_ON: begin
                if (pwr_ack_i) begin
                    state_d      = CLK_ON;
                    tmr_load     = 1'b1;
                    tmr_load_val = LD_SETTLE;
`ifdef CLUSTER_SEQ_TIMEOUT_EN
                end else if (tmr_zero) begin
                    state_d      = PWR_OFF;
                    err_d        = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = LD_TMO;
`endif
                end
            end

            CLK_ON: begin
                if (tmr_zero) begin
                    state_d      = RST_REL;
                    tmr_load     = 1'b1;
                    tmr_load_val = LD_RST;
                end
            end

            RST_REL: begin
                if (tmr_zero) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end
            end

            RUN: begin
                if (accept) begin
                    if (!cmd_in.pwr_up) begin
                        state_d = DRAIN;
`ifdef CLUSTER_SEQ_TIMEOUT_EN
                        tmr_load     = 1'b1;
                        tmr_load_val = LD_TMO;
`endif
                    end else begin
                        done_d = 1'b1;  // already running: acknowledge only
                    end
                end
            end

            DRAIN: begin
                if (!cluster_busy_i && idle_q) begin
                    state_d = RST_ASSERT;
`ifdef CLUSTER_SEQ_TIMEOUT_EN
                end else if (tmr_zero) begin
                    state_d = RST_ASSERT;  // forced shutdown of a stuck cluster
                    err_d   = 1'b1;
`endif
                end
            end

            RST_ASSERT: begin
                state_d = PWR_OFF;
`ifdef CLUSTER_SEQ_TIMEOUT_EN
                tmr_load     = 1'b1;
                tmr_load_val = LD_TMO;
`endif
            end

            PWR_OFF: begin
                if (!pwr_ack_i) begin
                    state_d = OFF;
                    done_d  = 1'b1;
`ifdef CLUSTER_SEQ_TIMEOUT_EN
                end else if (tmr_zero) begin
                    state_d = OFF;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
`endif
                end
            end

            default: begin
                state_d = OFF;
            end
        endcase

`ifdef CLUSTER_SEQ_TIMEOUT_EN
        // Accepts only happen in OFF/RUN where no timeout can fire, so the
        // clear never races with a set.
        if (accept) begin
            err_d = 1'b0;
        end
`endif

        cmd_ready_d = (state_d == OFF) || (state_d == RUN);

        // Cluster-facing levels decode the current state and land one cycle later.
        pow_d    = (state_q != OFF) && (state_q != PWR_OFF);
        clk_en_d = state_q inside {CLK_ON, RST_REL, RUN, DRAIN, RST_ASSERT};
        rstn_d   = state_q inside {RUN, DRAIN};
        fetch_d  = (state_q == RUN) && fetch_flag_q;
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= OFF;
            cmd_ready_q  <= 1'b1;
            pow_q        <= 1'b0;
            clk_en_q     <= 1'b0;
            rstn_q       <= 1'b0;
            fetch_q      <= 1'b0;
            done_q       <= 1'b0;
            idle_q       <= 1'b0;
            fetch_flag_q <= 1'b0;
            boot_addr_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            pow_q        <= pow_d;
            clk_en_q     <= clk_en_d;
            rstn_q       <= rstn_d;
            fetch_q      <= fetch_d;
            done_q       <= done_d;
            idle_q       <= idle_d;
            fetch_flag_q <= fetch_flag_d;
            boot_addr_q  <= boot_addr_d;
        end
    end

`ifdef CLUSTER_SEQ_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign cmd_ready_o            = cmd_ready_q;
    assign cluster_pow_o          = pow_q;
    assign cluster_clk_en_o       = clk_en_q;
    assign cluster_rstn_o         = rstn_q;
    assign cluster_fetch_enable_o = fetch_q;
    assign cluster_boot_addr_o    = boot_addr_q;
    assign state_o                = state_q;
    assign done_o                 = done_q;

endmodule

// File: tb/tb_cluster_pwr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cluster_pwr_seq_ctrl
// Directed + randomized bench. Expected behaviour is expressed as predicted
// cycle numbers of each output edge, derived from the handshake cycle and the
// documented wait lengths; a monitor records when each output actually moved.
// -----------------------------------------------------------------------------
module tb_cluster_pwr_seq_ctrl;
    import cluster_seq_pkg::*;

    localparam int AW = 64;
    localparam int CS = 4;
    localparam int RC = 16;
    localparam int TO = 1024;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic          cmd_pwr_up_i = 1'b0;
    logic          cmd_fetch_en_i = 1'b0;
    logic [AW-1:0] cmd_boot_addr_i = '0;
    logic          pwr_ack_i = 1'b0;
    logic          cluster_busy_i = 1'b0;
    logic          cluster_pow_o;
    logic          cluster_clk_en_o;
    logic          cluster_rstn_o;
    logic          cluster_fetch_enable_o;
    logic [AW-1:0] cluster_boot_addr_o;
    logic [2:0]    state_o;
    logic          done_o;
    logic          err_o;

    cluster_pwr_seq_ctrl #(
        .BOOT_ADDR_W (AW),
        .CLK_SETTLE  (CS),
        .RST_CYCLES  (RC),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .cmd_valid_i            (cmd_valid_i),
        .cmd_ready_o            (cmd_ready_o),
        .cmd_pwr_up_i           (cmd_pwr_up_i),
        .cmd_fetch_en_i         (cmd_fetch_en_i),
        .cmd_boot_addr_i        (cmd_boot_addr_i),
        .pwr_ack_i              (pwr_ack_i),
        .cluster_busy_i         (cluster_busy_i),
        .cluster_pow_o          (cluster_pow_o),
        .cluster_clk_en_o       (cluster_clk_en_o),
        .cluster_rstn_o         (cluster_rstn_o),
        .cluster_fetch_enable_o (cluster_fetch_enable_o),
        .cluster_boot_addr_o    (cluster_boot_addr_o),
        .state_o                (state_o),
        .done_o                 (done_o),
        .err_o                  (err_o)
    );

    always #5 clk_i = ~clk_i;

    // cyc = number of rising edges seen; stable when read at a falling edge.
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Edge recorder: cycle number of the last rise/fall of each output.
    logic pow_p = 1'b0, clk_p = 1'b0, rstn_p = 1'b0, fe_p = 1'b0;
    int t_pow_r = -1, t_pow_f = -1, t_clk_r = -1, t_clk_f = -1;
    int t_rstn_r = -1, t_rstn_f = -1, t_fe_r = -1, t_fe_f = -1;
    int done_cnt = 0, t_done = -1;

    always @(negedge clk_i) begin
        if (cluster_pow_o && !pow_p)           t_pow_r  <= cyc;
        if (!cluster_pow_o && pow_p)           t_pow_f  <= cyc;
        if (cluster_clk_en_o && !clk_p)        t_clk_r  <= cyc;
        if (!cluster_clk_en_o && clk_p)        t_clk_f  <= cyc;
        if (cluster_rstn_o && !rstn_p)         t_rstn_r <= cyc;
        if (!cluster_rstn_o && rstn_p)         t_rstn_f <= cyc;
        if (cluster_fetch_enable_o && !fe_p)   t_fe_r   <= cyc;
        if (!cluster_fetch_enable_o && fe_p)   t_fe_f   <= cyc;
        if (done_o) begin
            done_cnt <= done_cnt + 1;
            t_done   <= cyc;
        end
        pow_p  <= cluster_pow_o;
        clk_p  <= cluster_clk_en_o;
        rstn_p <= cluster_rstn_o;
        fe_p   <= cluster_fetch_enable_o;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk_i);
    endtask

    // Power-up with ack raised d cycles after the accept edge; waits into RUN.
    task automatic up_seq(input logic [63:0] addr, input logic fe, input int d);
        int a, t, d0;
        d0 = done_cnt;
        cmd_valid_i = 1'b1; cmd_pwr_up_i = 1'b1; cmd_fetch_en_i = fe; cmd_boot_addr_i = addr;
        a = cyc + 1;
        tick(1);
        cmd_valid_i = 1'b0; cmd_boot_addr_i = ~addr;
        check("up_ready_drop", cmd_ready_o, 1'b0);
        check("up_state_pwr_on", state_o, PWR_ON);
        wait_to(a + d);
        pwr_ack_i = 1'b1;
        t = a + d + 1;  // ack sampled on the next edge
        wait_to(t + CS + RC + 2);
        check("up_pow_rise", t_pow_r, a + 1);
        check("up_clk_rise", t_clk_r, t + 1);
        check("up_rstn_after_clk", t_rstn_r - t_clk_r, CS + RC);
        if (fe) check("up_fe_rise", t_fe_r, t + CS + RC + 1);
        else    check("up_fe_low", cluster_fetch_enable_o, 1'b0);
        check("up_boot_addr", cluster_boot_addr_o, addr);
        check("up_done_count", done_cnt - d0, 1);
        check("up_done_time", t_done, t + CS + RC);
        check("up_state_run", state_o, RUN);
        check("up_ready_run", cmd_ready_o, 1'b1);
    endtask

    // Power-down with cluster busy for b cycles after accept, ack dropped e
    // cycles after power is released.
    task automatic down_seq(input int b, input int e, input logic had_fe, input logic [63:0] addr);
        int dd, r, p, d0;
        d0 = done_cnt;
        cluster_busy_i = (b > 0);
        cmd_valid_i = 1'b1; cmd_pwr_up_i = 1'b0;
        dd = cyc + 1;
        tick(1);
        cmd_valid_i = 1'b0;
        check("dn_state_drain", state_o, DRAIN);
        check("dn_ready_drop", cmd_ready_o, 1'b0);
        wait_to(dd + b);
        cluster_busy_i = 1'b0;
        r = dd + b + 2;  // two idle samples, then RST_ASSERT
        wait_to(r);
        check("dn_rstn_held_while_busy", cluster_rstn_o, 1'b1);
        wait_to(r + 2 + e);
        pwr_ack_i = 1'b0;
        p = r + 3 + e;
        wait_to(p + 2);
        if (had_fe) check("dn_fe_fall", t_fe_f, dd + 1);
        check("dn_rstn_fall", t_rstn_f, r + 1);
        check("dn_clk_fall", t_clk_f, r + 2);
        check("dn_pow_fall", t_pow_f, r + 2);
        check("dn_done_count", done_cnt - d0, 1);
        check("dn_done_time", t_done, p);
        check("dn_state_off", state_o, OFF);
        check("dn_ready_off", cmd_ready_o, 1'b1);
        check("dn_boot_addr_kept", cluster_boot_addr_o, addr);
    endtask

    // Command that matches the current state: only a done pulse, no output change.
    task automatic noop(input logic up);
        logic p, c, r, f;
        logic [63:0] a;
        logic [2:0] s;
        p = cluster_pow_o; c = cluster_clk_en_o; r = cluster_rstn_o;
        f = cluster_fetch_enable_o; a = cluster_boot_addr_o; s = state_o;
        cmd_valid_i = 1'b1; cmd_pwr_up_i = up; cmd_fetch_en_i = ~f;
        cmd_boot_addr_i = {$urandom, $urandom};
        tick(1);
        cmd_valid_i = 1'b0;
        check("noop_done", done_o, 1'b1);
        check("noop_ready", cmd_ready_o, 1'b1);
        check("noop_state", state_o, s);
        check("noop_outs", {cluster_pow_o, cluster_clk_en_o, cluster_rstn_o, cluster_fetch_enable_o},
              {p, c, r, f});
        check("noop_addr", cluster_boot_addr_o, a);
        tick(1);
        check("noop_done_pulse", done_o, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] addr;
        logic        fe;
        int          a, t, dd, r, p, d0, fe_r0;

        // ---------------- reset state ----------------
        tick(3);
        check("rst_state", state_o, OFF);
        check("rst_outs", {cluster_pow_o, cluster_clk_en_o, cluster_rstn_o,
                           cluster_fetch_enable_o, done_o, err_o}, 6'b0);
        check("rst_addr", cluster_boot_addr_o, 64'h0);
        check("rst_ready", cmd_ready_o, 1'b1);
        rst_ni = 1'b1;
        tick(1);

        // ---------------- directed up / down ----------------
        up_seq(64'h1C008080, 1'b1, 3);
        down_seq(10, 2, 1'b1, 64'h1C008080);

        // ---------------- no-op commands ----------------
        noop(1'b0);
        addr = {$urandom, $urandom};
        up_seq(addr, 1'b1, $urandom_range(0, 6));
        noop(1'b1);
        down_seq($urandom_range(0, 12), $urandom_range(0, 4), 1'b1, addr);

        // ---------------- randomized round trips ----------------
        for (int i = 0; i < 3; i++) begin
            addr = {$urandom, $urandom};
            fe   = 1'($urandom_range(0, 1));
            up_seq(addr, fe, $urandom_range(0, 6));
            down_seq($urandom_range(0, 12), $urandom_range(0, 4), fe, addr);
        end

        // ---------------- held valid during bring-up, fetch_en=0, ack glitch ----------------
        addr  = {$urandom, $urandom};
        d0    = done_cnt;
        fe_r0 = t_fe_r;
        cmd_valid_i = 1'b1; cmd_pwr_up_i = 1'b1; cmd_fetch_en_i = 1'b0; cmd_boot_addr_i = addr;
        a = cyc + 1;
        tick(1);
        cmd_valid_i = 1'b0;
        wait_to(a + 1);
        pwr_ack_i = 1'b1;
        t = a + 2;
        wait_to(t + 1);
        check("hold_ready_clk_on", cmd_ready_o, 1'b0);
        cmd_valid_i = 1'b1; cmd_pwr_up_i = 1'b0; cmd_fetch_en_i = 1'b1;
        wait_to(t + CS + 1);
        pwr_ack_i = 1'b0;  // glitch while in RST_REL
        tick(1);
        pwr_ack_i = 1'b1;
        wait_to(t + CS + RC - 1);
        check("hold_not_accepted", state_o, RST_REL);
        tick(1);
        check("hold_state_run", state_o, RUN);
        check("hold_fe_low_run", cluster_fetch_enable_o, 1'b0);
        tick(1);
        dd = t + CS + RC + 1;
        cmd_valid_i = 1'b0;
        check("hold_accept_in_run", state_o, DRAIN);
        check("hold_rstn_up", cluster_rstn_o, 1'b1);
        r = dd + 2;
        wait_to(r + 2);
        pwr_ack_i = 1'b0;
        p = r + 3;
        wait_to(p + 2);
        check("hold_rstn_rise", t_rstn_r, t + CS + RC + 1);
        check("hold_rstn_fall", t_rstn_f, r + 1);
        check("hold_fe_never", t_fe_r, fe_r0);
        check("hold_done_count", done_cnt - d0, 2);
        check("hold_state_off", state_o, OFF);

        // ---------------- reset in RST_REL ----------------
        pwr_ack_i = 1'b1;
        cmd_valid_i = 1'b1; cmd_pwr_up_i = 1'b1; cmd_fetch_en_i = 1'b1;
        cmd_boot_addr_i = {$urandom, $urandom};
        a = cyc + 1;
        tick(1);
        cmd_valid_i = 1'b0;
        t = a + 1;
        wait_to(t + CS + 3);
        check("mrst_in_rst_rel", state_o, RST_REL);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mrst_state", state_o, OFF);
        check("mrst_outs", {cluster_pow_o, cluster_clk_en_o, cluster_rstn_o,
                            cluster_fetch_enable_o, done_o, err_o}, 6'b0);
        check("mrst_addr", cluster_boot_addr_o, 64'h0);
        check("mrst_ready", cmd_ready_o, 1'b1);
        pwr_ack_i = 1'b0;
        tick(1);
        rst_ni = 1'b1;
        tick(2);

        // ---------------- ack never arrives ----------------
        d0 = done_cnt;
        cmd_valid_i = 1'b1; cmd_pwr_up_i = 1'b1; cmd_fetch_en_i = 1'b1;
        addr = {$urandom, $urandom};
        cmd_boot_addr_i = addr;
        a = cyc + 1;
        tick(1);
        cmd_valid_i = 1'b0;
`ifdef CLUSTER_SEQ_TIMEOUT_EN
        wait_to(a + TO - 1);
        check("tmo_still_waiting", state_o, PWR_ON);
        wait_to(a + TO + 3);
        check("tmo_pow_fall", t_pow_f, a + TO + 1);
        check("tmo_err", err_o, 1'b1);
        check("tmo_state_off", state_o, OFF);
        check("tmo_done_time", t_done, a + TO + 1);
        noop(1'b0);
        check("tmo_err_cleared", err_o, 1'b0);
`else
        wait_to(a + TO + 40);
        check("notmo_still_waiting", state_o, PWR_ON);
        check("notmo_pow_high", cluster_pow_o, 1'b1);
        check("notmo_err_low", err_o, 1'b0);
        pwr_ack_i = 1'b1;
        t = cyc + 1;
        wait_to(t + CS + RC + 2);
        check("notmo_run", state_o, RUN);
        check("notmo_done_time", t_done, t + CS + RC);
        down_seq(0, 1, 1'b1, addr);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
